// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared core constants for the instruction cache: word and
//               line geometry, address field positions and FSM encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

  // Line geometry
  localparam int unsigned c_word_bits   = 32;
  localparam int unsigned c_line_words  = 4;

  // Address field positions: [1:0] byte-in-word, [3:2] word-in-line,
  // index starts at bit 4, tag occupies everything above the index.
  localparam int unsigned c_offset_lsb  = 2;
  localparam int unsigned c_offset_bits = 2;
  localparam int unsigned c_index_lsb   = c_offset_lsb + c_offset_bits;
  localparam int unsigned c_line_bits   = c_word_bits - c_index_lsb;

  // Refill controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : icache_pkg
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// ============================================================================
// Module      : icache_array
// Description : Storage for the direct-mapped instruction cache: tag memory,
//               per-line valid bits and line data. One asynchronous read port
//               (addressed by lookup index/offset) and one synchronous write
//               port (refill word, optionally committing tag and valid).
// Ports       : clk, rst        - clock, synchronous active-high reset
//               rd_index/offset - lookup address; rd_valid/rd_tag/rd_word out
//               wr_en           - write wr_data into [wr_index][wr_offset]
//               wr_commit       - with wr_en: also write wr_tag, set valid
//               inval_all       - clear every valid bit
// Revision    : 1.0 - initial release
// ============================================================================
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned TAG_BITS   = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INDEX_BITS-1:0]    rd_index,
  input  logic [c_offset_bits-1:0] rd_offset,
  output logic                     rd_valid,
  output logic [TAG_BITS-1:0]      rd_tag,
  output logic [c_word_bits-1:0]   rd_word,
  input  logic                     wr_en,
  input  logic                     wr_commit,
  input  logic [INDEX_BITS-1:0]    wr_index,
  input  logic [c_offset_bits-1:0] wr_offset,
  input  logic [c_word_bits-1:0]   wr_data,
  input  logic [TAG_BITS-1:0]      wr_tag,
  input  logic                     inval_all
);

  localparam int unsigned c_lines = 2 ** INDEX_BITS;

  logic [c_lines-1:0]     r_valid;
  logic [TAG_BITS-1:0]    r_tag  [c_lines];
  logic [c_word_bits-1:0] r_data [c_lines][c_line_words];

  // Only the valid bits are reset; tag/data contents are meaningless
  // until their valid bit is set by a completed refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      if (inval_all) begin
        r_valid <= '0;
      end
      if (wr_en && wr_commit) begin
        r_valid[wr_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_data[wr_index][wr_offset] <= wr_data;
      if (wr_commit) begin
        r_tag[wr_index] <= wr_tag;
      end
    end
  end

  assign rd_valid = r_valid[rd_index];
  assign rd_tag   = r_tag[rd_index];
  assign rd_word  = r_data[rd_index][rd_offset];

endmodule : icache_array
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module      : icache
// Description : Read-only direct-mapped instruction cache with a zero-latency
//               combinational hit path and a word-serial refill engine.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               rd_req/rd_addr    - fetch request and byte address
//               rd_wait/rd_data   - stall flag and instruction word
//               flush             - single-cycle invalidate-all request
//               bus_req/bus_addr  - refill word request to memory
//               bus_ack/bus_rdata - refill word return
// Revision    : 1.0 - initial release
// ============================================================================
module icache
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned LINE_WORDS = c_line_words
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [c_word_bits-1:0] rd_addr,
  input  logic                   rd_req,
  output logic                   rd_wait,
  output logic [c_word_bits-1:0] rd_data,
  input  logic                   flush,
  output logic                   bus_req,
  output logic [c_word_bits-1:0] bus_addr,
  input  logic                   bus_ack,
  input  logic [c_word_bits-1:0] bus_rdata
);

  localparam int unsigned c_tag_bits = c_line_bits - INDEX_BITS;
  localparam int unsigned c_cnt_bits = $clog2(LINE_WORDS);

  // Lookup address fields
  logic [INDEX_BITS-1:0]    w_index;
  logic [c_tag_bits-1:0]    w_tag;
  logic [c_offset_bits-1:0] w_offset;
  logic [1:0]               w_addr_unused;

  assign w_index       = rd_addr[c_index_lsb +: INDEX_BITS];
  assign w_tag         = rd_addr[c_word_bits-1 -: c_tag_bits];
  assign w_offset      = rd_addr[c_offset_lsb +: c_offset_bits];
  assign w_addr_unused = rd_addr[1:0];

  // Controller state
  state_t                 r_state,  w_state_nxt;
  logic [c_cnt_bits-1:0]  r_count,  w_count_nxt;
  logic                   r_flush_pending, w_flush_pending_nxt;
  logic [c_line_bits-1:0] r_miss_line, w_miss_line_nxt;

  // Array interface
  logic                   w_arr_valid;
  logic [c_tag_bits-1:0]  w_arr_tag;
  logic [c_word_bits-1:0] w_arr_word;
  logic                   w_wr_en;
  logic                   w_wr_commit;
  logic                   w_inval_all;
  logic                   w_hit;

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (c_tag_bits)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (w_index),
    .rd_offset (w_offset),
    .rd_valid  (w_arr_valid),
    .rd_tag    (w_arr_tag),
    .rd_word   (w_arr_word),
    .wr_en     (w_wr_en),
    .wr_commit (w_wr_commit),
    .wr_index  (r_miss_line[INDEX_BITS-1:0]),
    .wr_offset (r_count),
    .wr_data   (bus_rdata),
    .wr_tag    (r_miss_line[c_line_bits-1 -: c_tag_bits]),
    .inval_all (w_inval_all)
  );

  // A lookup may only hit in IDLE when no invalidation is due on this edge:
  // a flush cycle, or the first IDLE cycle after a deferred flush, must not
  // serve data from lines that are about to be invalidated.
  assign w_hit = rd_req && (r_state == ST_IDLE) && !flush && !r_flush_pending
                 && w_arr_valid && (w_arr_tag == w_tag);

  assign rd_wait = !w_hit;
  assign rd_data = w_arr_word;

  // Line base plus word offset; the offset field of the line base is zero,
  // so concatenation is equivalent to the addition.
  assign bus_addr = {r_miss_line, r_count, {c_offset_lsb{1'b0}}};

  always_comb begin
    w_state_nxt         = r_state;
    w_count_nxt         = r_count;
    w_flush_pending_nxt = r_flush_pending;
    w_miss_line_nxt     = r_miss_line;
    w_wr_en             = 1'b0;
    w_wr_commit         = 1'b0;
    w_inval_all         = 1'b0;
    bus_req             = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (flush || r_flush_pending) begin
          w_inval_all         = 1'b1;
          w_flush_pending_nxt = 1'b0;
        end
        // A deferred flush takes this IDLE cycle for itself; the miss is
        // taken on the following cycle with all lines already invalid.
        if (rd_req && !w_hit && !r_flush_pending) begin
          w_state_nxt     = ST_FILL;
          w_miss_line_nxt = rd_addr[c_word_bits-1:c_index_lsb];
          w_count_nxt     = '0;
        end
      end

      ST_FILL: begin
        bus_req = 1'b1;
        if (flush) begin
          w_flush_pending_nxt = 1'b1;
        end
        if (bus_ack) begin
          w_wr_en     = 1'b1;
          w_count_nxt = r_count + 1'b1;
          if (r_count == c_cnt_bits'(LINE_WORDS - 1)) begin
            w_wr_commit = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (flush) begin
          w_flush_pending_nxt = 1'b1;
        end
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_count         <= '0;
      r_flush_pending <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_count         <= w_count_nxt;
      r_flush_pending <= w_flush_pending_nxt;
    end
  end

  // Only meaningful while a refill is outstanding; no reset needed.
  always_ff @(posedge clk) begin
    r_miss_line <= w_miss_line_nxt;
  end

endmodule : icache
`default_nettype wire
